// File: rtl/tube_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with blanking gap.
// Optional per-digit blinking is compiled in with TUBE_BLINK_EN.
module tube_scan_ctrl #(
  parameter int PRESCALE = 5000,
  parameter int BLANK    = 16
`ifdef TUBE_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
`ifdef TUBE_BLINK_EN
  input  logic [5:0] blink_mask,
`endif
  output logic [5:0] DIG,
  output logic [4:0] num,
  output logic       slot_tick,
  output logic       frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL   = CW'(BLANK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    slot, slot_n, idx;
  logic [5:0]    d [6];
  logic [5:0]    shadow, shadow_n;
  logic [5:0]    dig_n;
  logic [4:0]    num_n;
  logic          tick_n, frame_n, dark_n;

`ifdef TUBE_BLINK_EN
  logic [7:0] fcnt, fcnt_n;
  logic       phase, phase_n;

  always_comb begin
    fcnt_n  = fcnt;
    phase_n = phase;
    if (!scan_en) begin
      fcnt_n  = '0;
      phase_n = 1'b0;
    end else if (frame_done) begin
      if (fcnt == 8'(BLINK_FRAMES - 1)) begin
        fcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        fcnt_n = fcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      fcnt  <= fcnt_n;
      phase <= phase_n;
    end
  end

  assign dark_n = phase_n & blink_mask[idx];
`else
  assign dark_n = 1'b0;
`endif

  // Outputs are built from the next-state values so they line up
  // with the state/cnt/slot that holds during the same cycle.
  always_comb begin
    state_n  = S_IDLE;
    cnt_n    = '0;
    slot_n   = '0;
    shadow_n = shadow;
    dig_n    = 6'h3f;
    num_n    = '0;
    if (scan_en) begin
      if (state == S_IDLE) begin
        cnt_n  = '0;
        slot_n = '0;
      end else if (cnt == LAST) begin
        cnt_n  = '0;
        slot_n = (slot >= 3'd5) ? 3'd0 : slot + 3'd1;
      end else begin
        cnt_n  = cnt + 1'b1;
        slot_n = (slot > 3'd5) ? 3'd0 : slot;
      end
      state_n = (cnt_n < BL) ? S_BLANK : S_SHOW;
    end
    idx = 3'd5 - slot_n;
    if (state_n == S_SHOW && cnt_n == BL) begin
      if (wr_en && wr_addr == idx)
        shadow_n = wr_data;
      else
        shadow_n = d[idx];
    end
    if (state_n == S_SHOW) begin
      dig_n[idx] = ~shadow_n[5] | dark_n;
      num_n      = shadow_n[4:0];
    end
    tick_n  = scan_en && cnt_n == LAST;
    frame_n = tick_n && slot_n == 3'd5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      slot       <= '0;
      shadow     <= '0;
      DIG        <= 6'h3f;
      num        <= '0;
      slot_tick  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 6; i++) d[i] <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      slot       <= slot_n;
      shadow     <= shadow_n;
      DIG        <= dig_n;
      num        <= num_n;
      slot_tick  <= tick_n;
      frame_done <= frame_n;
      if (wr_en && wr_addr <= 3'd5) d[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Bench for tube_scan_ctrl: frame-position model plus directed pins.
// Covers the blink option too when TUBE_BLINK_EN is defined.
module tb_tube_scan_ctrl;

  localparam int P  = 8;
  localparam int BL = 2;
  localparam int BF = 2;

  logic       clk = 0;
  logic       rst_n;
  logic       scan_en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic [5:0] DIG;
  logic [4:0] num;
  logic       slot_tick;
  logic       frame_done;
`ifdef TUBE_BLINK_EN
  logic [5:0] blink_mask;
`endif

  int n_chk = 0;
  int n_fail = 0;

  tube_scan_ctrl #(
    .PRESCALE(P),
    .BLANK(BL)
`ifdef TUBE_BLINK_EN
    ,
    .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`ifdef TUBE_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .DIG(DIG),
    .num(num),
    .slot_tick(slot_tick),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position p counts cycles since scanning began; slot and
  // in-slot count follow from plain division.
  int         mp;
  bit         mrun;
  logic [5:0] md [6];
  logic [5:0] msh;
  logic [5:0] e_dig;
  logic [4:0] e_num;
  logic       e_tick, e_frame;
  int         mc, ms, mk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrun = 0;
      mp = 0;
      msh = 0;
      for (int i = 0; i < 6; i++) md[i] = 0;
      e_dig = 6'h3f;
      e_num = 0;
      e_tick = 0;
      e_frame = 0;
    end else begin
      if (wr_en && wr_addr <= 5) md[wr_addr] = wr_data;
      if (!scan_en) begin
        mrun = 0;
        mp = 0;
      end else if (!mrun) begin
        mrun = 1;
        mp = 0;
      end else begin
        mp++;
      end
      e_dig = 6'h3f;
      e_num = 0;
      e_tick = 0;
      e_frame = 0;
      if (mrun) begin
        mc = mp % P;
        ms = (mp / P) % 6;
        mk = 5 - ms;
        if (mc == BL) msh = md[mk];
        if (mc >= BL) begin
          e_dig[mk] = ~msh[5];
          e_num = msh[4:0];
`ifdef TUBE_BLINK_EN
          if (((mp / (6 * P)) / BF) % 2 == 1 && blink_mask[mk])
            e_dig[mk] = 1'b1;
`endif
        end
        e_tick = (mc == P - 1);
        e_frame = e_tick && ms == 5;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dig", DIG, e_dig);
      chk("num", num, e_num);
      chk("slot_tick", slot_tick, e_tick);
      chk("frame_done", frame_done, e_frame);
    end
  end

  task automatic wait_p(int x);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (mrun && mp == x) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_p: position %0d never reached", x);
  endtask

  task automatic wr(int a, logic [5:0] v);
    wr_en = 1;
    wr_addr = 3'(a);
    wr_data = v;
  endtask

  initial begin
    rst_n = 0;
    scan_en = 0;
    wr_en = 0;
    wr_addr = 0;
    wr_data = 0;
`ifdef TUBE_BLINK_EN
    blink_mask = 6'b000001;
`endif
    repeat (3) @(negedge clk);
    chk("rst_dig", DIG, 6'h3f);
    chk("rst_num", num, 0);
    chk("rst_tick", slot_tick, 0);
    chk("rst_frame", frame_done, 0);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      wr(k, {1'b1, 5'(k)});
      @(negedge clk);
    end
    wr(6, 6'h3f);
    @(negedge clk);
    wr_en = 0;
    scan_en = 1;

    wait_p(0);
    chk("first_dark", DIG, 6'h3f);
    wait_p(2);
    chk("s0_dig", DIG, 6'b011111);
    chk("s0_num", num, 5);
    wait_p(7);
    chk("s0_tick", slot_tick, 1);
    wait_p(10);
    chk("s1_dig", DIG, 6'b101111);
    chk("s1_num", num, 4);
    wait_p(47);
    chk("s5_frame", frame_done, 1);
    chk("s5_dig", DIG, 6'b111110);

    wait_p(50);
    wr(3, {1'b0, 5'd9});
    @(negedge clk);
    wr_en = 0;
    wait_p(68);
    chk("d3_off_dig", DIG, 6'h3f);
    chk("d3_off_num", num, 9);

    wait_p(99);
    wr(5, {1'b1, 5'd17});
    @(negedge clk);
    wr_en = 0;
    wait_p(101);
    chk("mid_write_old", num, 5);
    wait_p(146);
    chk("mid_write_new", num, 17);
    wait_p(153);
    wr(4, {1'b1, 5'd20});
    @(negedge clk);
    wr_en = 0;
    chk("bypass_num", num, 20);
    chk("bypass_dig", DIG, 6'b101111);

    wait_p(220);
    scan_en = 0;
    @(negedge clk);
    chk("abort_dig", DIG, 6'h3f);
    chk("abort_tick", slot_tick, 0);
    repeat (4) @(negedge clk);
    scan_en = 1;
    wait_p(0);
    chk("restart_dark", DIG, 6'h3f);
    wait_p(2);
    chk("restart_num", num, 17);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wr_en = ($urandom % 4 == 0);
      wr_addr = 3'($urandom % 8);
      wr_data = 6'($urandom);
      if (!scan_en) scan_en = ($urandom % 4 == 0);
      else scan_en = ($urandom % 400 != 0);
`ifdef TUBE_BLINK_EN
      if ($urandom % 500 == 0) blink_mask = 6'($urandom);
`endif
    end

    @(negedge clk);
    wr_en = 0;
    #2 rst_n = 0;
    #1;
    chk("async_dig", DIG, 6'h3f);
    chk("async_num", num, 0);
    chk("async_tick", slot_tick, 0);
    @(negedge clk);
    @(negedge clk);
    scan_en = 0;
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_dark", DIG, 6'h3f);
    scan_en = 1;
    repeat (120) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
